// File: rtl/rggen_checked_bus_splitter.sv
// Fans one register-bus access out to TOTAL_REGISTERS register ports and returns a checked response.
// The optional access watchdog is built when RGGEN_BUS_SPLITTER_TIMEOUT_EN is defined.
`timescale 1ns/1ps
module rggen_checked_bus_splitter #(
  parameter int DATA_WIDTH      = 32,
  parameter int ADDRESS_WIDTH   = 16,
  parameter int TOTAL_REGISTERS = 1,
  parameter int TIMEOUT_CYCLES  = 16
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  bus_request_i,
  input  logic [ADDRESS_WIDTH-1:0]              bus_address_i,
  input  logic                                  bus_direction_i,
  input  logic [DATA_WIDTH-1:0]                 bus_write_data_i,
  input  logic [DATA_WIDTH/8-1:0]               bus_write_strobe_i,
  output logic                                  bus_done_o,
  output logic                                  bus_read_done_o,
  output logic                                  bus_write_done_o,
  output logic [DATA_WIDTH-1:0]                 bus_read_data_o,
  output logic [1:0]                            bus_status_o,
  output logic [TOTAL_REGISTERS-1:0]            reg_request_o,
  output logic [ADDRESS_WIDTH-1:0]              reg_address_o,
  output logic                                  reg_direction_o,
  output logic [DATA_WIDTH-1:0]                 reg_write_data_o,
  output logic [DATA_WIDTH/8-1:0]               reg_write_strobe_o,
  input  logic [TOTAL_REGISTERS-1:0]            reg_select_i,
  input  logic [TOTAL_REGISTERS-1:0]            reg_ready_i,
  input  logic [TOTAL_REGISTERS*DATA_WIDTH-1:0] reg_read_data_i,
  input  logic [2*TOTAL_REGISTERS-1:0]          reg_status_i,
  output logic [2:0]                            error_info
);

  localparam logic       RGGEN_WRITE       = 1'b1;
  localparam logic [1:0] RGGEN_OKAY        = 2'b00;
  localparam logic [1:0] RGGEN_SLAVE_ERROR = 2'b10;
  localparam logic [TOTAL_REGISTERS-1:0] SEL_ONE = TOTAL_REGISTERS'(1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ACCESS   = 2'd1,
    RESPONSE = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic                    done_q, done_d;
  logic                    read_done_q, read_done_d;
  logic                    write_done_q, write_done_d;
  logic [DATA_WIDTH-1:0]   read_data_q, read_data_d;
  logic [1:0]              status_q, status_d;
  logic [2:0]              error_q, error_d;

  logic                    active;
  logic                    hit_none;
  logic                    hit_multi;
  logic                    qualified_ready;
  logic                    timeout;
  logic                    tmo_reached;
  logic                    complete;
  logic [DATA_WIDTH-1:0]   sel_data;
  logic [1:0]              sel_status;

  assign reg_address_o      = bus_address_i;
  assign reg_direction_o    = bus_direction_i;
  assign reg_write_data_o   = bus_write_data_i;
  assign reg_write_strobe_o = bus_write_strobe_i;
  assign reg_request_o      = (state_q != RESPONSE) ? {TOTAL_REGISTERS{bus_request_i}} : '0;

  assign active          = (state_q != RESPONSE) && bus_request_i;
  assign hit_none        = ~|reg_select_i;
  // Clearing the lowest set bit leaves something only when two or more selects are high.
  assign hit_multi       = |(reg_select_i & (reg_select_i - SEL_ONE));
  assign qualified_ready = |(reg_ready_i & reg_select_i);
  assign timeout         = !hit_none && !hit_multi && !qualified_ready && tmo_reached;
  assign complete        = active && (hit_multi || hit_none || qualified_ready || timeout);

  always_comb begin
    sel_data   = '0;
    sel_status = '0;
    for (int i = 0; i < TOTAL_REGISTERS; i++) begin
      if (reg_select_i[i]) begin
        sel_data   = sel_data | reg_read_data_i[i*DATA_WIDTH +: DATA_WIDTH];
        sel_status = sel_status | reg_status_i[2*i +: 2];
      end
    end
  end

`ifdef RGGEN_BUS_SPLITTER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] wdog_q, wdog_d;

  assign tmo_reached = (wdog_q == TMO_LAST);
  assign wdog_d      = (active && !complete) ? wdog_q + CNT_W'(1) : '0;

  always_ff @(posedge clk) begin
    if (!rst_n) wdog_q <= '0;
    else        wdog_q <= wdog_d;
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
  assign tmo_reached        = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    done_d       = 1'b0;
    read_done_d  = 1'b0;
    write_done_d = 1'b0;
    read_data_d  = '0;
    status_d     = RGGEN_OKAY;
    error_d      = 3'b000;
    case (state_q)
      IDLE, ACCESS: begin
        if (!bus_request_i) begin
          state_d = IDLE;
        end else if (complete) begin
          state_d      = RESPONSE;
          done_d       = 1'b1;
          read_done_d  = (bus_direction_i != RGGEN_WRITE);
          write_done_d = (bus_direction_i == RGGEN_WRITE);
          if (hit_multi) begin
            status_d   = RGGEN_SLAVE_ERROR;
            error_d[1] = 1'b1;
          end else if (hit_none) begin
            status_d   = RGGEN_SLAVE_ERROR;
            error_d[0] = 1'b1;
          end else if (qualified_ready) begin
            status_d    = sel_status;
            read_data_d = (bus_direction_i == RGGEN_WRITE) ? '0 : sel_data;
          end else begin
            status_d   = RGGEN_SLAVE_ERROR;
            error_d[2] = 1'b1;
          end
        end else begin
          state_d = ACCESS;
        end
      end
      RESPONSE: state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      done_q       <= 1'b0;
      read_done_q  <= 1'b0;
      write_done_q <= 1'b0;
      read_data_q  <= '0;
      status_q     <= RGGEN_OKAY;
      error_q      <= 3'b000;
    end else begin
      state_q      <= state_d;
      done_q       <= done_d;
      read_done_q  <= read_done_d;
      write_done_q <= write_done_d;
      read_data_q  <= read_data_d;
      status_q     <= status_d;
      error_q      <= error_d;
    end
  end

  assign bus_done_o       = done_q;
  assign bus_read_done_o  = read_done_q;
  assign bus_write_done_o = write_done_q;
  assign bus_read_data_o  = read_data_q;
  assign bus_status_o     = status_q;
  assign error_info       = error_q;

endmodule

// File: tb/tb_rggen_checked_bus_splitter.sv
// Bench for rggen_checked_bus_splitter: vector table with a response scoreboard plus
// hand-written abort, back-to-back and mid-access reset sequences.
`timescale 1ns/1ps
module tb_rggen_checked_bus_splitter;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] EXOKAY = 2'b01;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam int         NEVER  = 1000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        bus_request;
  logic [15:0] bus_address;
  logic        bus_direction;
  logic [31:0] bus_write_data;
  logic [3:0]  bus_write_strobe;
  logic        bus_done, bus_read_done, bus_write_done;
  logic [31:0] bus_read_data;
  logic [1:0]  bus_status;
  logic [3:0]  reg_request;
  logic [15:0] reg_address;
  logic        reg_direction;
  logic [31:0] reg_write_data;
  logic [3:0]  reg_write_strobe;
  logic [3:0]  reg_select, reg_ready;
  logic [127:0] reg_read_data;
  logic [7:0]  reg_status;
  logic [2:0]  error_info;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        dir;
    logic [3:0]  sel;
    logic [3:0]  rdy_pre;
    logic [3:0]  rdy;
    int          rdy_cyc;
    int          exp_cyc;
    logic [1:0]  exp_status;
    logic [31:0] exp_rdata;
    logic [2:0]  exp_err;
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];

  rggen_checked_bus_splitter #(
    .DATA_WIDTH      (32),
    .ADDRESS_WIDTH   (16),
    .TOTAL_REGISTERS (4),
    .TIMEOUT_CYCLES  (4)
  ) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .bus_request_i      (bus_request),
    .bus_address_i      (bus_address),
    .bus_direction_i    (bus_direction),
    .bus_write_data_i   (bus_write_data),
    .bus_write_strobe_i (bus_write_strobe),
    .bus_done_o         (bus_done),
    .bus_read_done_o    (bus_read_done),
    .bus_write_done_o   (bus_write_done),
    .bus_read_data_o    (bus_read_data),
    .bus_status_o       (bus_status),
    .reg_request_o      (reg_request),
    .reg_address_o      (reg_address),
    .reg_direction_o    (reg_direction),
    .reg_write_data_o   (reg_write_data),
    .reg_write_strobe_o (reg_write_strobe),
    .reg_select_i       (reg_select),
    .reg_ready_i        (reg_ready),
    .reg_read_data_i    (reg_read_data),
    .reg_status_i       (reg_status),
    .error_info         (error_info)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus_request = 1'b0;
    reg_select  = 4'b0000;
    reg_ready   = 4'b0000;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    vec_t e;
    bit   seen;
    int   c;
    seen = 0;
    c    = 0;
    exp_q.push_back(v);
    while (!seen && c < 40) begin
      bus_request      = 1'b1;
      bus_direction    = v.dir;
      bus_address      = 16'h0100 + idx[15:0];
      bus_write_data   = 32'hA5A5_0000 ^ idx;
      bus_write_strobe = 4'hF;
      reg_select       = v.sel;
      reg_ready        = (c >= v.rdy_cyc) ? v.rdy : v.rdy_pre;
      @(negedge clk);
      if (c == 0) begin
        chk($sformatf("v%0d addr_bcast", idx), {16'h0, reg_address}, {16'h0, bus_address});
        chk($sformatf("v%0d req_fwd", idx), {28'h0, reg_request}, 32'hF);
      end
      if (bus_done) begin
        seen = 1;
        if (exp_q.size() == 0) begin
          chk($sformatf("v%0d unexpected_done", idx), 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk($sformatf("v%0d latency", idx), c, e.exp_cyc);
          chk($sformatf("v%0d status", idx), {30'h0, bus_status}, {30'h0, e.exp_status});
          chk($sformatf("v%0d read_data", idx), bus_read_data, e.exp_rdata);
          chk($sformatf("v%0d error_info", idx), {29'h0, error_info}, {29'h0, e.exp_err});
          chk($sformatf("v%0d read_done", idx), {31'h0, bus_read_done}, {31'h0, !e.dir});
          chk($sformatf("v%0d write_done", idx), {31'h0, bus_write_done}, {31'h0, e.dir});
          chk($sformatf("v%0d req_masked", idx), {28'h0, reg_request}, 32'h0);
        end
      end
      next_cycle();
      c++;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL v%0d done_timeout: no done within %0d cycles", idx, c);
      exp_q.delete();
    end
    idle_inputs();
    @(negedge clk);
    chk($sformatf("v%0d done_pulse", idx), {31'h0, bus_done}, 32'h0);
    next_cycle();
  endtask

  task automatic add_vec(input logic dir, input logic [3:0] sel, input logic [3:0] rdy_pre,
                         input logic [3:0] rdy, input int rdy_cyc, input int exp_cyc,
                         input logic [1:0] st, input logic [31:0] rd, input logic [2:0] err);
    vec_t v;
    v.dir = dir; v.sel = sel; v.rdy_pre = rdy_pre; v.rdy = rdy; v.rdy_cyc = rdy_cyc;
    v.exp_cyc = exp_cyc; v.exp_status = st; v.exp_rdata = rd; v.exp_err = err;
    vecs.push_back(v);
  endtask

  initial begin
    int dones;
    reg_read_data    = {32'h4444_5555, 32'hCAFE_F00D, 32'h2222_3333, 32'h1111_0000};
    reg_status       = {OKAY, OKAY, EXOKAY, OKAY};
    bus_address      = 16'h0;
    bus_direction    = 1'b0;
    bus_write_data   = 32'h0;
    bus_write_strobe = 4'h0;

    // dir, sel, rdy_pre, rdy, rdy_cyc, exp_cyc, status, read_data, error_info
    add_vec(1'b0, 4'b0100, 4'b0000, 4'b0100, 2,     3, OKAY,   32'hCAFE_F00D, 3'b000);
    add_vec(1'b1, 4'b0000, 4'b0000, 4'b0000, 0,     1, SLVERR, 32'h0,         3'b001);
    add_vec(1'b0, 4'b0011, 4'b0000, 4'b0011, 0,     1, SLVERR, 32'h0,         3'b010);
    add_vec(1'b0, 4'b0001, 4'b0010, 4'b0011, 3,     4, OKAY,   32'h1111_0000, 3'b000);
    add_vec(1'b1, 4'b0010, 4'b0000, 4'b0010, 0,     1, EXOKAY, 32'h0,         3'b000);
    add_vec(1'b0, 4'b0010, 4'b0000, 4'b0010, 1,     2, EXOKAY, 32'h2222_3333, 3'b000);
    add_vec(1'b0, 4'b1000, 4'b0000, 4'b1000, 0,     1, OKAY,   32'h4444_5555, 3'b000);
    add_vec(1'b0, 4'b0000, 4'b0000, 4'b1111, 0,     1, SLVERR, 32'h0,         3'b001);
`ifdef RGGEN_BUS_SPLITTER_TIMEOUT_EN
    add_vec(1'b0, 4'b1000, 4'b0000, 4'b0000, NEVER, 4, SLVERR, 32'h0,         3'b100);
    add_vec(1'b0, 4'b1000, 4'b0000, 4'b1000, 3,     4, OKAY,   32'h4444_5555, 3'b000);
`else
    add_vec(1'b0, 4'b1000, 4'b0000, 4'b1000, 20,    21, OKAY,  32'h4444_5555, 3'b000);
`endif

    // Reset held with a request that would otherwise complete immediately.
    rst_n       = 1'b0;
    bus_request = 1'b1;
    reg_select  = 4'b0000;
    reg_ready   = 4'b0000;
    next_cycle();
    next_cycle();
    @(negedge clk);
    chk("reset done", {31'h0, bus_done}, 32'h0);
    chk("reset status", {30'h0, bus_status}, {30'h0, OKAY});
    chk("reset read_data", bus_read_data, 32'h0);
    chk("reset error_info", {29'h0, error_info}, 32'h0);
    idle_inputs();
    rst_n = 1'b1;
    next_cycle();

    for (int i = 0; i < vecs.size(); i++) run_vec(i, vecs[i]);

    // Abort: request held without ready for cycles 0-1, dropped in cycle 2.
    dones = 0;
    for (int c = 0; c < 7; c++) begin
      bus_request = (c < 2);
      reg_select  = 4'b0010;
      reg_ready   = 4'b0000;
      @(negedge clk);
      if (bus_done) dones++;
      next_cycle();
    end
    chk("abort no_done", dones, 0);
    idle_inputs();
    run_vec(100, vecs[6]);

    // Back-to-back: held request with ready completes every other cycle.
    dones = 0;
    for (int c = 0; c < 7; c++) begin
      bus_request   = 1'b1;
      bus_direction = 1'b0;
      reg_select    = 4'b0100;
      reg_ready     = 4'b0100;
      @(negedge clk);
      if (bus_done !== ((c % 2) == 1)) dones++;
      next_cycle();
    end
    chk("b2b done_pattern_errs", dones, 0);
    idle_inputs();
    next_cycle();
    next_cycle();

    // Reset for one cycle mid-access, in the cycle where ready would complete it.
    bus_request = 1'b1;
    reg_select  = 4'b0100;
    reg_ready   = 4'b0000;
    next_cycle();
    next_cycle();
    rst_n     = 1'b0;
    reg_ready = 4'b0100;
    next_cycle();
    rst_n = 1'b1;
    idle_inputs();
    @(negedge clk);
    chk("midrst done", {31'h0, bus_done}, 32'h0);
    chk("midrst read_done", {31'h0, bus_read_done}, 32'h0);
    chk("midrst read_data", bus_read_data, 32'h0);
    chk("midrst status", {30'h0, bus_status}, {30'h0, OKAY});
    chk("midrst error_info", {29'h0, error_info}, 32'h0);
    dones = 0;
    for (int c = 0; c < 4; c++) begin
      next_cycle();
      @(negedge clk);
      if (bus_done) dones++;
    end
    chk("midrst no_done", dones, 0);
    next_cycle();
    run_vec(101, vecs[0]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rggen_checked_bus_splitter.md
# rggen_checked_bus_splitter

Successor to the register-block bus splitter. Fans one `rggen_bus_if` access out to `TOTAL_REGISTERS` register interfaces and collects the response through an explicit access state machine. Adds the following over the plain splitter:
- one-hot hit checking
- request masking during the response cycle
- ready qualification by select
- an optional watchdog that terminates accesses to registers that never respond

It sits between the bus-protocol adapter and the register instances of every generated block.

## Interface
- `DATA_WIDTH`, default 32: bus and register data width.
- `TOTAL_REGISTERS`, default 1: number of register interfaces (≥1).
- `TIMEOUT_CYCLES`, default 16: watchdog limit in cycles (≥1). Used only with the timeout macro.
- `clk`: input, 1 bit. Clock.
- `rst_n`: input, 1 bit. Reset, active low, synchronous to `clk`.
- `bus_if`: `rggen_bus_if.slave`. Fields used:
  - inputs: request, address, direction, write_data, write_strobe
  - outputs: done, read_done, write_done, read_data, status
- `register_if[TOTAL_REGISTERS]`: `rggen_register_if.master`.
  - Drives: request, address, direction, write_data, write_strobe.
  - Samples: select, ready, read_data, status.
- `error_info`: output, 3 bits. Pulses with `done`.
  - [0] no register hit
  - [1] multiple registers hit
  - [2] timeout

## Operation
- **States:** IDLE, ACCESS, RESPONSE. Reset state is IDLE.
- **Request forwarding:**
  - address, direction, write_data and write_strobe are broadcast combinationally to all register interfaces.
  - `register_if[i].request` = `bus_if.request` in IDLE and ACCESS, forced 0 in RESPONSE.
- **Hit evaluation:** combinational, every cycle, in IDLE or ACCESS while `bus_if.request` = 1.
  - hit_count = popcount(select).
  - qualified_ready = |(ready & select). Ready from unselected registers is ignored.
- **Completion:** in IDLE or ACCESS with request = 1, the first matching condition completes the access, in priority order:
  1. hit_count ≥ 2: error, `error_info[1]`.
  2. hit_count = 0: error, `error_info[0]`.
  3. hit_count = 1 and qualified_ready: OK path.
  4. Timeout (macro enabled): error, `error_info[2]`.
- **On completion:**
  - Next state is RESPONSE.
  - Registered outputs are loaded:
    - done = 1
    - read_done = (direction == RGGEN_READ)
    - write_done = (direction == RGGEN_WRITE)
  - OK path:
    - status = selected register's status
    - read_data = selected read_data for reads, 0 for writes
  - Error path: status = RGGEN_SLAVE_ERROR, read_data = 0.
- **No completion:**
  - IDLE with request = 1 moves to ACCESS.
  - Request = 0 in IDLE or ACCESS moves to IDLE. This is an abort with no done pulse.
- **RESPONSE:** unconditionally moves to IDLE next cycle. All registered outputs return to:
  - done = 0, read_done = 0, write_done = 0
  - read_data = 0, status = RGGEN_OKAY, error_info = 0
- **Reset:** all registered outputs are cleared to the same values as the RESPONSE exit. state = IDLE, watchdog counter = 0.
- **Reset mid-access:** the access is abandoned; no done is produced for it.

## Timing
- **Latency:** done asserts the cycle after the completion condition.
  - Minimum: request and ready in cycle 0, done in cycle 1.
- **done:** exactly one-cycle pulse. Registers see request = 0 during the done cycle.
- **Throughput:** a request held high after done is re-evaluated from cycle 2, so the peak rate is one access per 2 cycles.
- **Watchdog:**
  - Counter width is $clog2(TIMEOUT_CYCLES+1).
  - The counter is 0 in IDLE and increments each ACCESS cycle.
  - Timeout fires in the cycle where the counter equals TIMEOUT_CYCLES−1 with no other completion. For a request first seen in cycle 0 with no ready, done and SLAVE_ERROR arrive in cycle TIMEOUT_CYCLES.
  - Ready in the same cycle as the timeout wins (OK path).
- **TIMEOUT_CYCLES = 1:** a request without ready in cycle 0 completes with a timeout in cycle 0.

## Configuration
- Macro: `RGGEN_BUS_SPLITTER_TIMEOUT_EN`.
- **Defined:** the watchdog counter and timeout completion exist as described above.
- **Undefined:**
  - No counter is built.
  - An access with a single hit waits indefinitely for qualified_ready.
  - `error_info[2]` is tied 0.
  - `TIMEOUT_CYCLES` is ignored.

## Test plan
- **Read hit:** TOTAL_REGISTERS=4. Read with select=4'b0100, ready in cycle 2, read_data=32'hCAFE_F00D, status OKAY → one-cycle done and read_done in cycle 3, read_data=32'hCAFE_F00D, error_info=0.
- **Write to unmapped address:** select=0 → done and write_done in cycle 1, status=RGGEN_SLAVE_ERROR, read_data=0, error_info=3'b001.
- **Multi-hit:** select=4'b0011 with both ready → SLAVE_ERROR, error_info=3'b010 in cycle 1; register request is low in cycle 1.
- **Unqualified ready:** select=4'b0001, ready=4'b0010 held for 3 cycles, then ready[0] → done only after ready[0]; the unselected ready never completes the access.
- **Timeout (macro on, TIMEOUT_CYCLES=4):** select=4'b1000, ready never asserted → done in cycle 4 with SLAVE_ERROR, error_info=3'b100. Repeat with ready[3] in cycle 3 → OK.
- **Abort and reset:**
  - Request dropped in cycle 2 of ACCESS → no done, state IDLE.
  - rst_n low for one cycle mid-ACCESS → all outputs zero/OKAY next cycle, no done.
